button_bcd_counter: RTL and testbench

Debounced push-button BCD digit counter that sits directly upstream of the BCD-to-7-segment decoder. It synchronises and debounces a raw active-low push button. Each accepted press advances a single BCD digit 0..9 with wrap-around. The `bcd` output drives the decoder's BCD input, and `carry` lets several instances be cascaded into a multi-digit counter.

---
 rtl/button_bcd_counter_if.sv | 12 +
 rtl/button_bcd_counter.sv | 105 ++++++++++
 tb/tb_button_bcd_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/button_bcd_counter_if.sv
// rtl/button_bcd_counter_if.sv - button/control inputs and BCD digit outputs of one counter stage
interface button_bcd_counter_if;
  logic       button;
  logic       enable;
  logic       clear;
  logic [3:0] bcd;
  logic       press;
  logic       carry;

  modport master (output button, enable, clear, input bcd, press, carry);
  modport slave  (input button, enable, clear, output bcd, press, carry);
endinterface

// File: rtl/button_bcd_counter.sv
// rtl/button_bcd_counter.sv - synchronised, debounced push button advancing one cascadable BCD digit
module button_bcd_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input logic                clk,
  input logic                rst,
  button_bcd_counter_if.slave bus
);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic [3:0]       r_bcd;
  logic             r_press;
  logic             r_carry;

  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] w_dcnt_nx;
  logic             w_accept;

  // Both stages reset to 1 so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_accept = (r_state == S_PRESS_WAIT) && !r_sync2 && (r_dcnt == C_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_dcnt_nx  = r_dcnt;
    case (r_state)
      S_RELEASED: begin
        if (!r_sync2) begin
          w_state_nx = S_PRESS_WAIT;
          w_dcnt_nx  = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (r_sync2)                w_state_nx = S_RELEASED;
        else if (r_dcnt == C_LAST)  w_state_nx = S_HELD;
        else                        w_dcnt_nx  = r_dcnt + 1'b1;
      end
      S_HELD: begin
        if (r_sync2) begin
          w_state_nx = S_RELEASE_WAIT;
          w_dcnt_nx  = '0;
        end
      end
      default: begin
        if (!r_sync2)               w_state_nx = S_HELD;
        else if (r_dcnt == C_LAST)  w_state_nx = S_RELEASED;
        else                        w_dcnt_nx  = r_dcnt + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RELEASED;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dcnt  <= w_dcnt_nx;
    end
  end

  // Any out-of-range digit reloads 0 on the next press instead of counting up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd   <= 4'd0;
      r_press <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_press <= w_accept;
      r_carry <= 1'b0;
      if (bus.clear) begin
        r_bcd <= 4'd0;
      end else if (w_accept && bus.enable) begin
        if (r_bcd >= 4'd9) r_bcd <= 4'd0;
        else               r_bcd <= r_bcd + 4'd1;
        r_carry <= (r_bcd == 4'd9);
      end
    end
  end

  assign bus.bcd   = r_bcd;
  assign bus.press = r_press;
  assign bus.carry = r_carry;

endmodule

// File: tb/tb_button_bcd_counter.sv
// tb/tb_button_bcd_counter.sv - directed self-checking bench for button_bcd_counter
module tb_button_bcd_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   press_cnt;
  int   carry_cnt;
  int   carry_alone;
  int   double_pulse;
  logic prev_press;
  logic prev_carry;
  int   p0;
  int   c0;
  int   lat;

  button_bcd_counter_if bus ();

  button_bcd_counter #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      prev_press = 1'b0;
      prev_carry = 1'b0;
    end else begin
      if (bus.press) press_cnt++;
      if (bus.carry) carry_cnt++;
      if (bus.carry && !bus.press) carry_alone++;
      if ((bus.press && prev_press) || (bus.carry && prev_carry)) double_pulse++;
      prev_press = bus.press;
      prev_carry = bus.carry;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_once(input int low_n, input int high_n);
    bus.button = 1'b0;
    tick(low_n);
    bus.button = 1'b1;
    tick(high_n);
  endtask

  // Drives button low just before edge 1 and returns the edge index where press shows
  task automatic timed_press(input int clear_edge, output int edge_idx);
    edge_idx = 0;
    bus.button = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      bus.clear = (i == clear_edge);
      @(posedge clk);
      #1;
      if (bus.press && edge_idx == 0) edge_idx = i;
    end
    bus.clear  = 1'b0;
    bus.button = 1'b1;
    tick(12);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    press_cnt = 0; carry_cnt = 0; carry_alone = 0; double_pulse = 0;
    prev_press = 1'b0; prev_carry = 1'b0;
    bus.button = 1'b1; bus.enable = 1'b1; bus.clear = 1'b0;
    rst = 1'b1;

    // Reset and idle
    tick(3);
    check("reset_bcd", 32'(bus.bcd), 0);
    check("reset_press", 32'(bus.press), 0);
    check("reset_carry", 32'(bus.carry), 0);
    rst = 1'b0;
    tick(20);
    check("idle_no_press", press_cnt, 0);
    check("idle_bcd", 32'(bus.bcd), 0);

    // Single clean press: button sampled low at edge 1, press after edge 7
    timed_press(0, lat);
    check("press_latency_edge", lat, 7);
    check("single_press_cnt", press_cnt, 1);
    check("single_bcd", 32'(bus.bcd), 1);
    tick(20);
    check("single_bcd_stable", 32'(bus.bcd), 1);

    // Bounce rejection
    p0 = press_cnt;
    press_once(2, 1);
    press_once(3, 10);
    check("bounce_no_press", press_cnt - p0, 0);
    check("bounce_bcd", 32'(bus.bcd), 1);

    // Held press with release glitches counts once
    press_once(10, 2);
    press_once(5, 2);
    press_once(5, 12);
    check("glitch_one_press", press_cnt - p0, 1);
    check("glitch_bcd", 32'(bus.bcd), 2);

    // Wrap and carry over ten presses
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check("clear_bcd", 32'(bus.bcd), 0);
    c0 = carry_cnt;
    for (int i = 1; i <= 10; i++) begin
      press_once(8, 8);
      check($sformatf("wrap_bcd_%0d", i), 32'(bus.bcd), 32'(i % 10));
    end
    check("wrap_carry_cnt", carry_cnt - c0, 1);
    check("carry_with_press", carry_alone, 0);

    // Enable gating at 5
    for (int i = 0; i < 5; i++) press_once(8, 8);
    check("gate_start_bcd", 32'(bus.bcd), 5);
    p0 = press_cnt;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) press_once(8, 8);
    bus.enable = 1'b1;
    check("gate_press_cnt", press_cnt - p0, 3);
    check("gate_bcd_hold", 32'(bus.bcd), 5);

    // Clear on the press edge at 9 overrides wrap and carry
    for (int i = 0; i < 4; i++) press_once(8, 8);
    check("pre_clear_bcd", 32'(bus.bcd), 9);
    c0 = carry_cnt;
    p0 = press_cnt;
    timed_press(7, lat);
    check("clear_press_edge", lat, 7);
    check("clear_over_press_bcd", 32'(bus.bcd), 0);
    check("clear_no_carry", carry_cnt - c0, 0);
    check("clear_press_pulse", press_cnt - p0, 1);

    // Reset while in PRESS_WAIT with dcnt=2 and button held
    press_once(8, 8);
    check("pre_rst_bcd", 32'(bus.bcd), 1);
    bus.button = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_bcd", 32'(bus.bcd), 0);
    check("midrst_press", 32'(bus.press), 0);
    check("midrst_carry", 32'(bus.carry), 0);
    tick(2);
    p0 = press_cnt;
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.press && lat == 0) lat = i;
    end
    check("post_rst_latency_edge", lat, 7);
    bus.button = 1'b1;
    tick(20);
    check("post_rst_one_press", press_cnt - p0, 1);
    check("post_rst_bcd", 32'(bus.bcd), 1);
    check("no_double_pulse", double_pulse, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
